// File: rtl/cpu_control_unit_if.sv
// Strobe/decode bundle between the control unit (master) and the single-bus datapath (slave).
interface cpu_control_unit_if #(
    parameter int OPW = 5
);
    logic [31:0]    ir;
    logic           con;
    logic           pci, pco, iri, mari, mdri, mdro;
    logic           mem_read, mem_write;
    logic           hii, hio, loi, loo, ryi, rzhi, rzli, rzho, rzlo;
    logic           ipo, opi, csigno, con_in, incpc;
    logic           gra, grb, grc, rin, rout, baout;
    logic [OPW-1:0] alu_op;
    logic           run;

    modport master (
        input  ir, con,
        output pci, pco, iri, mari, mdri, mdro, mem_read, mem_write,
               hii, hio, loi, loo, ryi, rzhi, rzli, rzho, rzlo,
               ipo, opi, csigno, con_in, incpc,
               gra, grb, grc, rin, rout, baout, alu_op, run
    );

    modport slave (
        output ir, con,
        input  pci, pco, iri, mari, mdri, mdro, mem_read, mem_write,
               hii, hio, loi, loo, ryi, rzhi, rzli, rzho, rzlo,
               ipo, opi, csigno, con_in, incpc,
               gra, grb, grc, rin, rout, baout, alu_op, run
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle Moore control FSM for the single-bus RISC datapath (fetch T0-T2, execute T3-T7).
// Optional macro CU_SINGLE_STEP_EN adds a step input that gates each fetch.
module cpu_control_unit #(
    parameter int             OPW    = 5,
    parameter logic [OPW-1:0] ADD_OP = 5'b00011
) (
    input  logic clock,
    input  logic clear,
`ifdef CU_SINGLE_STEP_EN
    input  logic step,
`endif
    cpu_control_unit_if.master cu
);

    typedef enum logic [3:0] {
        S_RESET, S_T0W, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_LD   = OPW'(0);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
    localparam logic [OPW-1:0] OP_ST   = OPW'(2);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
    localparam logic [OPW-1:0] OP_ROL  = OPW'(11);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(12);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(14);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(15);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(16);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(17);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(18);
    localparam logic [OPW-1:0] OP_BR   = OPW'(19);
    localparam logic [OPW-1:0] OP_JR   = OPW'(20);
    localparam logic [OPW-1:0] OP_IN   = OPW'(22);
    localparam logic [OPW-1:0] OP_OUT  = OPW'(23);
    localparam logic [OPW-1:0] OP_MFHI = OPW'(24);
    localparam logic [OPW-1:0] OP_MFLO = OPW'(25);
    localparam logic [OPW-1:0] OP_HALT = OPW'(27);

`ifdef CU_SINGLE_STEP_EN
    localparam state_t FETCH_START = S_T0W;
`else
    localparam state_t FETCH_START = S_T0;
`endif

    state_t         state, state_next;
    logic [OPW-1:0] opcode;
    logic           is_ld, is_ldi, is_st, is_alu, is_imm, is_muldiv, is_negnot, is_br;
    logic           is_jr, is_in, is_out, is_mfhi, is_mflo, is_halt;
    logic [2:0]     n_exec;

    assign opcode = cu.ir[31 -: OPW];

    // Opcode classes and the number of execute steps each class occupies
    always_comb begin
        is_ld     = (opcode == OP_LD);
        is_ldi    = (opcode == OP_LDI);
        is_st     = (opcode == OP_ST);
        is_alu    = (opcode >= OP_ADD) && (opcode <= OP_ROL);
        is_imm    = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
        is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
        is_negnot = (opcode == OP_NEG) || (opcode == OP_NOT);
        is_br     = (opcode == OP_BR);
        is_jr     = (opcode == OP_JR);
        is_in     = (opcode == OP_IN);
        is_out    = (opcode == OP_OUT);
        is_mfhi   = (opcode == OP_MFHI);
        is_mflo   = (opcode == OP_MFLO);
        is_halt   = (opcode == OP_HALT);
        n_exec    = 3'd1;
        if (is_ld || is_st)                   n_exec = 3'd5;
        else if (is_muldiv || is_br)          n_exec = 3'd4;
        else if (is_alu || is_imm || is_ldi)  n_exec = 3'd3;
        else if (is_negnot)                   n_exec = 3'd2;
    end

    always_ff @(posedge clock) begin
        if (!clear) state <= S_RESET;
        else        state <= state_next;
    end

    always_comb begin
        state_next = FETCH_START;
        case (state)
            S_RESET: state_next = FETCH_START;
`ifdef CU_SINGLE_STEP_EN
            S_T0W:   state_next = step ? S_T0 : S_T0W;
`endif
            S_T0:    state_next = S_T1;
            S_T1:    state_next = S_T2;
            S_T2:    state_next = S_T3;
            S_T3:    state_next = is_halt ? S_HALT : ((n_exec > 3'd1) ? S_T4 : FETCH_START);
            S_T4:    state_next = (n_exec > 3'd2) ? S_T5 : FETCH_START;
            S_T5:    state_next = (n_exec > 3'd3) ? S_T6 : FETCH_START;
            S_T6:    state_next = (n_exec > 3'd4) ? S_T7 : FETCH_START;
            S_T7:    state_next = FETCH_START;
            S_HALT:  state_next = S_HALT;
            default: state_next = FETCH_START;
        endcase
    end

    // Strobes are pure functions of state and opcode; con only matters in the branch commit step
    always_comb begin
        cu.pci = 1'b0;  cu.pco = 1'b0;  cu.iri = 1'b0;  cu.mari = 1'b0;
        cu.mdri = 1'b0; cu.mdro = 1'b0; cu.mem_read = 1'b0; cu.mem_write = 1'b0;
        cu.hii = 1'b0;  cu.hio = 1'b0;  cu.loi = 1'b0;  cu.loo = 1'b0;
        cu.ryi = 1'b0;  cu.rzhi = 1'b0; cu.rzli = 1'b0; cu.rzho = 1'b0; cu.rzlo = 1'b0;
        cu.ipo = 1'b0;  cu.opi = 1'b0;  cu.csigno = 1'b0; cu.con_in = 1'b0; cu.incpc = 1'b0;
        cu.gra = 1'b0;  cu.grb = 1'b0;  cu.grc = 1'b0;  cu.rin = 1'b0;
        cu.rout = 1'b0; cu.baout = 1'b0;
        cu.run    = (state != S_RESET) && (state != S_HALT);
        cu.alu_op = '0;

        case (state)
            S_T0W, S_T0, S_T1, S_T2: cu.alu_op = ADD_OP;
            S_T3, S_T4, S_T5, S_T6, S_T7:
                cu.alu_op = (is_ld || is_ldi || is_st || is_br) ? ADD_OP : opcode;
            default: cu.alu_op = '0;
        endcase

        case (state)
            S_T0: begin cu.pco = 1'b1; cu.mari = 1'b1; cu.incpc = 1'b1; cu.rzli = 1'b1; end
            S_T1: begin cu.rzlo = 1'b1; cu.pci = 1'b1; cu.mem_read = 1'b1; cu.mdri = 1'b1; end
            S_T2: begin cu.mdro = 1'b1; cu.iri = 1'b1; end
            S_T3: begin
                if (is_alu || is_imm) begin
                    cu.grb = 1'b1; cu.rout = 1'b1; cu.ryi = 1'b1;
                end else if (is_ldi || is_ld || is_st) begin
                    cu.grb = 1'b1; cu.baout = 1'b1; cu.ryi = 1'b1;
                end else if (is_muldiv) begin
                    cu.gra = 1'b1; cu.rout = 1'b1; cu.ryi = 1'b1;
                end else if (is_negnot) begin
                    cu.grb = 1'b1; cu.rout = 1'b1; cu.rzli = 1'b1;
                end else if (is_br) begin
                    cu.gra = 1'b1; cu.rout = 1'b1; cu.con_in = 1'b1;
                end else if (is_jr) begin
                    cu.gra = 1'b1; cu.rout = 1'b1; cu.pci = 1'b1;
                end else if (is_in) begin
                    cu.ipo = 1'b1; cu.gra = 1'b1; cu.rin = 1'b1;
                end else if (is_out) begin
                    cu.gra = 1'b1; cu.rout = 1'b1; cu.opi = 1'b1;
                end else if (is_mfhi) begin
                    cu.hio = 1'b1; cu.gra = 1'b1; cu.rin = 1'b1;
                end else if (is_mflo) begin
                    cu.loo = 1'b1; cu.gra = 1'b1; cu.rin = 1'b1;
                end
            end
            S_T4: begin
                if (is_alu) begin
                    cu.grc = 1'b1; cu.rout = 1'b1; cu.rzli = 1'b1;
                end else if (is_imm || is_ldi || is_ld || is_st) begin
                    cu.csigno = 1'b1; cu.rzli = 1'b1;
                end else if (is_muldiv) begin
                    cu.grb = 1'b1; cu.rout = 1'b1; cu.rzhi = 1'b1; cu.rzli = 1'b1;
                end else if (is_negnot) begin
                    cu.rzlo = 1'b1; cu.gra = 1'b1; cu.rin = 1'b1;
                end else if (is_br) begin
                    cu.pco = 1'b1; cu.ryi = 1'b1;
                end
            end
            S_T5: begin
                if (is_alu || is_imm || is_ldi) begin
                    cu.rzlo = 1'b1; cu.gra = 1'b1; cu.rin = 1'b1;
                end else if (is_ld || is_st) begin
                    cu.rzlo = 1'b1; cu.mari = 1'b1;
                end else if (is_muldiv) begin
                    cu.rzlo = 1'b1; cu.loi = 1'b1;
                end else if (is_br) begin
                    cu.csigno = 1'b1; cu.rzli = 1'b1;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    cu.mem_read = 1'b1; cu.mdri = 1'b1;
                end else if (is_st) begin
                    cu.gra = 1'b1; cu.rout = 1'b1; cu.mdri = 1'b1;
                end else if (is_muldiv) begin
                    cu.rzho = 1'b1; cu.hii = 1'b1;
                end else if (is_br && cu.con) begin
                    cu.rzlo = 1'b1; cu.pci = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    cu.mdro = 1'b1; cu.gra = 1'b1; cu.rin = 1'b1;
                end else if (is_st) begin
                    cu.mem_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: per-instruction strobe sequences against a table-driven model.
// Honours CU_SINGLE_STEP_EN by holding step high and expecting one idle T0 cycle per instruction.
module tb_cpu_control_unit;

    localparam logic [4:0] ADD_OP = 5'b00011;

    localparam logic [27:0] PCI    = 28'd1 << 0;
    localparam logic [27:0] PCO    = 28'd1 << 1;
    localparam logic [27:0] IRI    = 28'd1 << 2;
    localparam logic [27:0] MARI   = 28'd1 << 3;
    localparam logic [27:0] MDRI   = 28'd1 << 4;
    localparam logic [27:0] MDRO   = 28'd1 << 5;
    localparam logic [27:0] MRD    = 28'd1 << 6;
    localparam logic [27:0] MWR    = 28'd1 << 7;
    localparam logic [27:0] HII    = 28'd1 << 8;
    localparam logic [27:0] HIO    = 28'd1 << 9;
    localparam logic [27:0] LOI    = 28'd1 << 10;
    localparam logic [27:0] LOO    = 28'd1 << 11;
    localparam logic [27:0] RYI    = 28'd1 << 12;
    localparam logic [27:0] RZHI   = 28'd1 << 13;
    localparam logic [27:0] RZLI   = 28'd1 << 14;
    localparam logic [27:0] RZHO   = 28'd1 << 15;
    localparam logic [27:0] RZLO   = 28'd1 << 16;
    localparam logic [27:0] IPO    = 28'd1 << 17;
    localparam logic [27:0] OPI    = 28'd1 << 18;
    localparam logic [27:0] CSIGNO = 28'd1 << 19;
    localparam logic [27:0] CONIN  = 28'd1 << 20;
    localparam logic [27:0] INCPC  = 28'd1 << 21;
    localparam logic [27:0] GRA    = 28'd1 << 22;
    localparam logic [27:0] GRB    = 28'd1 << 23;
    localparam logic [27:0] GRC    = 28'd1 << 24;
    localparam logic [27:0] RIN    = 28'd1 << 25;
    localparam logic [27:0] ROUT   = 28'd1 << 26;
    localparam logic [27:0] BAOUT  = 28'd1 << 27;

    logic clock = 1'b0;
    logic clear = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [27:0] exp_q[$];

    always #5 clock = ~clock;

    cpu_control_unit_if cu ();

`ifdef CU_SINGLE_STEP_EN
    logic step = 1'b1;
    cpu_control_unit #(.OPW(5), .ADD_OP(ADD_OP)) dut (
        .clock(clock), .clear(clear), .step(step), .cu(cu)
    );
`else
    cpu_control_unit #(.OPW(5), .ADD_OP(ADD_OP)) dut (
        .clock(clock), .clear(clear), .cu(cu)
    );
`endif

    function automatic logic [27:0] observed();
        return {cu.baout, cu.rout, cu.rin, cu.grc, cu.grb, cu.gra, cu.incpc, cu.con_in,
                cu.csigno, cu.opi, cu.ipo, cu.rzlo, cu.rzho, cu.rzli, cu.rzhi, cu.ryi,
                cu.loo, cu.loi, cu.hio, cu.hii, cu.mem_write, cu.mem_read, cu.mdro, cu.mdri,
                cu.mari, cu.iri, cu.pco, cu.pci};
    endfunction

    // Reference: the full list of per-cycle strobe sets for one instruction, fetch included
    task automatic build_expected(input logic [4:0] op, input logic c);
        int o;
        o = int'(op);
        exp_q.delete();
        exp_q.push_back(PCO | MARI | INCPC | RZLI);
        exp_q.push_back(RZLO | PCI | MRD | MDRI);
        exp_q.push_back(MDRO | IRI);
        if (o >= 3 && o <= 11) begin
            exp_q.push_back(GRB | ROUT | RYI);
            exp_q.push_back(GRC | ROUT | RZLI);
            exp_q.push_back(RZLO | GRA | RIN);
        end else if ((o >= 12 && o <= 14) || o == 1) begin
            exp_q.push_back((o == 1) ? (GRB | BAOUT | RYI) : (GRB | ROUT | RYI));
            exp_q.push_back(CSIGNO | RZLI);
            exp_q.push_back(RZLO | GRA | RIN);
        end else if (o == 0 || o == 2) begin
            exp_q.push_back(GRB | BAOUT | RYI);
            exp_q.push_back(CSIGNO | RZLI);
            exp_q.push_back(RZLO | MARI);
            exp_q.push_back((o == 0) ? (MRD | MDRI) : (GRA | ROUT | MDRI));
            exp_q.push_back((o == 0) ? (MDRO | GRA | RIN) : MWR);
        end else if (o == 15 || o == 16) begin
            exp_q.push_back(GRA | ROUT | RYI);
            exp_q.push_back(GRB | ROUT | RZHI | RZLI);
            exp_q.push_back(RZLO | LOI);
            exp_q.push_back(RZHO | HII);
        end else if (o == 17 || o == 18) begin
            exp_q.push_back(GRB | ROUT | RZLI);
            exp_q.push_back(RZLO | GRA | RIN);
        end else if (o == 19) begin
            exp_q.push_back(GRA | ROUT | CONIN);
            exp_q.push_back(PCO | RYI);
            exp_q.push_back(CSIGNO | RZLI);
            exp_q.push_back(c ? (RZLO | PCI) : 28'd0);
        end else if (o == 20) exp_q.push_back(GRA | ROUT | PCI);
        else if (o == 22) exp_q.push_back(IPO | GRA | RIN);
        else if (o == 23) exp_q.push_back(GRA | ROUT | OPI);
        else if (o == 24) exp_q.push_back(HIO | GRA | RIN);
        else if (o == 25) exp_q.push_back(LOO | GRA | RIN);
        else exp_q.push_back(28'd0);
    endtask

    task automatic check_idle(input string name, input logic exp_run, input bit chk_alu);
        checks++;
        if (observed() !== 28'd0) begin
            errors++;
            $display("[TB] FAIL %s strobes got=%h want=0", name, observed());
        end
        checks++;
        if (cu.run !== exp_run) begin
            errors++;
            $display("[TB] FAIL %s run got=%b want=%b", name, cu.run, exp_run);
        end
        if (chk_alu) begin
            checks++;
            if (cu.alu_op !== 5'd0) begin
                errors++;
                $display("[TB] FAIL %s alu_op got=%b want=00000", name, cu.alu_op);
            end
        end
    endtask

    // Runs one instruction from T0; abort_at>=0 pulls clear low during that step index
    task automatic exec_instr(input string name, input logic [31:0] irv, input logic c,
                              input int abort_at);
        logic [4:0] op;
        logic [4:0] exp_alu;
        bit         aborted;
        op      = irv[31:27];
        aborted = 0;
        build_expected(op, c);
`ifdef CU_SINGLE_STEP_EN
        @(posedge clock); #1;
        cu.ir = $urandom;
        #1;
        checks++;
        if (observed() !== 28'd0 || cu.run !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s step-wait got=%h/%b want=0/1", name, observed(), cu.run);
        end
`endif
        for (int k = 0; k < exp_q.size() && !aborted; k++) begin
            @(posedge clock); #1;
            cu.ir  = (k < 3) ? $urandom : irv;
            cu.con = (k == 6) ? c : 1'($urandom_range(0, 1));
            #1;
            exp_alu = (k < 3 || op == 5'd0 || op == 5'd1 || op == 5'd2 || op == 5'd19)
                      ? ADD_OP : op;
            checks++;
            if (observed() !== exp_q[k]) begin
                errors++;
                $display("[TB] FAIL %s T%0d strobes got=%h want=%h", name, k, observed(), exp_q[k]);
            end
            checks++;
            if (cu.run !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s T%0d run got=%b want=1", name, k, cu.run);
            end
            checks++;
            if (cu.alu_op !== exp_alu) begin
                errors++;
                $display("[TB] FAIL %s T%0d alu_op got=%b want=%b", name, k, cu.alu_op, exp_alu);
            end
            if (k == abort_at) begin
                clear   = 1'b0;
                aborted = 1;
            end
        end
        if (aborted) begin
            @(posedge clock); #2;
            check_idle({name, " abort"}, 1'b0, 1'b1);
            clear = 1'b1;
        end else if (op == 5'd27) begin
            for (int i = 0; i < 20; i++) begin
                @(posedge clock); #2;
                check_idle({name, " halted"}, 1'b0, 1'b0);
            end
            clear = 1'b0;
            @(posedge clock); #2;
            check_idle({name, " restart-reset"}, 1'b0, 1'b1);
            clear = 1'b1;
        end
    endtask

    task automatic test_reset();
        cu.ir  = 32'h0;
        cu.con = 1'b0;
        clear  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #2;
            check_idle("reset", 1'b0, 1'b1);
        end
        clear = 1'b1;
    endtask

    task automatic test_add();
        exec_instr("add", 32'h18000000, 1'b0, -1);
    endtask

    task automatic test_ld();
        exec_instr("ld", 32'h00000000, 1'b1, -1);
        exec_instr("ldi", 32'h08A00010, 1'b0, -1);
    endtask

    task automatic test_branch();
        exec_instr("br_con0", 32'h98000000, 1'b0, -1);
        exec_instr("br_con1", 32'h98000000, 1'b1, -1);
    endtask

    task automatic test_reset_mid_st();
        exec_instr("st_abort", 32'h10000000, 1'b0, 5);
        exec_instr("st_full", 32'h10123456, 1'b1, -1);
    endtask

    task automatic test_halt();
        exec_instr("halt", 32'hD8000000, 1'b0, -1);
        exec_instr("nop_after_halt", 32'hD0000000, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] irv;
        for (int n = 0; n < 60; n++) begin
            irv = $urandom;
            if (irv[31:27] == 5'd27) irv[31:27] = 5'd26;
            exec_instr("random", irv, 1'($urandom_range(0, 1)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ld();
        test_branch();
        test_reset_mid_st();
        test_back_to_back();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Multi-cycle Moore control FSM for the single-bus RISC datapath.
- Sequences fetch (T0–T2) and per-opcode execute steps (T3–T7) by driving the datapath strobes.
- Reads the IR value and the CON flip-flop output.
- One step per clock; returns to fetch after the last step of each instruction.

Parameters:
- OPW, 5, opcode width (ir[31:27])
- ADD_OP, 5'b00011, ALU code forced for address/PC arithmetic

Ports:
- clock  input  1  system clock, rising edge
- clear  input  1  synchronous active-low reset
- ir  input  32  IR register contents; opcode = ir[31:27]
- con  input  1  branch condition from CON FF
- pci, pco, iri, mari, mdri, mdro  output  1 each  PC/IR/MAR/MDR load/drive strobes
- mem_read, mem_write  output  1 each  RAM read (also MDR mux select) / write
- hii, hio, loi, loo, ryi, rzhi, rzli, rzho, rzlo  output  1 each  HI/LO/Y/Z load/drive strobes
- ipo, opi, csigno, con_in, incpc  output  1 each  inport drive, outport load, C-sign drive, CON load, ALU B:=1 for PC increment
- gra, grb, grc, rin, rout, baout  output  1 each  select-and-encode controls
- alu_op  output  5  ALU operation: ADD_OP during fetch/ld/ldi/st/br, else ir[31:27]
- run  output  1  high while executing; low in RESET/HALT

Behaviour:
- States: RESET, T0..T7, HALT. Outputs decoded combinationally from state and opcode; each listed strobe is high for exactly one cycle; all unlisted strobes are 0.
- Reset: clear=0 at a rising edge → RESET, all outputs 0, run=0. Next edge with clear=1 → T0. Reset mid-instruction aborts it, with no partial strobes after the edge.
- Fetch:
  - T0: pco, mari, incpc, rzli.
  - T1: rzlo, pci, mem_read, mdri.
  - T2: mdro, iri.
  - T2 → T3.
- Execute by opcode:
  - 00011–01011 (add, sub, and, or, shr, shra, shl, ror, rol):
    - T3: grb, rout, ryi.
    - T4: grc, rout, rzli.
    - T5: rzlo, gra, rin.
  - 01100–01110 (addi, andi, ori):
    - T3: grb, rout, ryi.
    - T4: csigno, rzli.
    - T5: rzlo, gra, rin.
  - 00001 (ldi): same as 01100–01110, except T3 uses grb, baout, ryi.
  - 00000 (ld):
    - T3: grb, baout, ryi.
    - T4: csigno, rzli.
    - T5: rzlo, mari.
    - T6: mem_read, mdri.
    - T7: mdro, gra, rin.
  - 00010 (st):
    - T3–T5: same as ld.
    - T6: gra, rout, mdri (mem_read=0 selects bus).
    - T7: mem_write.
  - 01111/10000 (mul/div):
    - T3: gra, rout, ryi.
    - T4: grb, rout, rzhi, rzli.
    - T5: rzlo, loi.
    - T6: rzho, hii.
  - 10001/10010 (neg/not):
    - T3: grb, rout, rzli.
    - T4: rzlo, gra, rin.
  - 10011 (br):
    - T3: gra, rout, con_in.
    - T4: pco, ryi.
    - T5: csigno, rzli.
    - T6: rzlo, pci only if con=1 (con sampled in T6); else no strobes.
  - 10100 (jr): T3: gra, rout, pci.
  - 10110 (in): T3: ipo, gra, rin.
  - 10111 (out): T3: gra, rout, opi.
  - 11000 (mfhi): T3: hio, gra, rin.
  - 11001 (mflo): T3: loo, gra, rin.
  - 11010 (nop), 10101 and 11100–11111 (reserved): T3 with no strobes.
  - 11011 (halt): T3 → HALT.
- After the last listed step, the next state is T0. Instruction latency is the fetch (3 cycles) plus the number of listed execute steps (nop: 4 cycles total, ld: 8 cycles).
- HALT: all strobes 0, run=0; held until clear=0.
- Opcode is taken from ir during T3–T7 only; ir changes during T0–T2 are ignored.

Optional Feature:
- CU_SINGLE_STEP_EN: adds input step (1 bit).
  - With the macro: in T0, the FSM holds in T0 (all strobes 0, run=1) until step=1 is sampled at a rising edge. The edge where step=1 is sampled is the first T0 cycle that drives the fetch strobes, giving one instruction per step pulse.
  - Without the macro: no step port; T0 always proceeds.

Test Plan:
- clear=0 for 2 cycles, then 1 → all outputs 0 during reset; T0 strobes (pco, mari, incpc, rzli) on the first cycle after release; iri high exactly on cycle 3.
- ir=32'h18000000 (add) → cycles 4–6 show {grb, rout, ryi}, {grc, rout, rzli}, {rzlo, gra, rin}; alu_op=00011; next cycle is T0.
- ir=32'h00000000 (ld) → mari in T5, mem_read+mdri in T6, mdro+gra+rin in T7; alu_op=ADD_OP throughout; 8-cycle total.
- ir=32'h98000000 (br) with con=0 at T6, then a repeat with con=1 → pci absent in the first run, pci+rzlo asserted in T6 of the second.
- ir=32'hD8000000 (halt) → run falls after T3 and stays 0 for 20 cycles with no strobes; clear=0 restarts at T0.
- clear=0 asserted in T5 of a st → RESET next cycle; mem_write never asserted.
